// File: rtl/hazard_ctrl_mc_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard controller (slave).
// dbg_state mirrors the controller FSM: 0 = RUN, 1 = LD_WAIT, 2 = MD_WAIT.
interface hazard_ctrl_mc_if #(parameter int AW = 5);
  // Handshakes: a MW load completes in the cycle load_rdy is high (Hold_MW is
  // held until then); md_start is a one-cycle launch and md_done is a
  // one-cycle completion pulse that is only honoured while a launch is pending.
  logic          valid_EX;
  logic [AW-1:0] raddr1;
  logic [AW-1:0] raddr2;
  logic          rs1_used;
  logic          rs2_used;
  logic          is_md_EX;
  logic          reg_wrMW;
  logic [AW-1:0] waddr_MW;
  logic          is_load_MW;
  logic          load_rdy;
  logic          md_done;
  logic          br_taken;
  logic [1:0]    For_A;
  logic [1:0]    For_B;
  logic          Stall;
  logic          Stall_MW;
  logic          Hold_MW;
  logic          Flush;
  logic          md_start;
  logic          md_timeout;
  logic [1:0]    dbg_state;

  modport master (
    output valid_EX, raddr1, raddr2, rs1_used, rs2_used, is_md_EX,
    output reg_wrMW, waddr_MW, is_load_MW, load_rdy, md_done, br_taken,
    input  For_A, For_B, Stall, Stall_MW, Hold_MW, Flush, md_start, md_timeout,
    input  dbg_state
  );

  modport slave (
    input  valid_EX, raddr1, raddr2, rs1_used, rs2_used, is_md_EX,
    input  reg_wrMW, waddr_MW, is_load_MW, load_rdy, md_done, br_taken,
    output For_A, For_B, Stall, Stall_MW, Hold_MW, Flush, md_start, md_timeout,
    output dbg_state
  );
endinterface

// File: rtl/hazard_ctrl_mc.sv
// Hazard controller for a 3-stage pipeline: MW/WB forwarding, load-use and
// variable-latency load stalls, multi-cycle mul/div issue with timeout, branch flush.
module hazard_ctrl_mc #(
  parameter int AW         = 5,
  parameter int MD_MAX_CYC = 34,
  parameter int FLUSH_CYC  = 1
) (
  input  logic             clk,
  input  logic             rst,
  hazard_ctrl_mc_if.slave  bus
);
  localparam int CW = $clog2(MD_MAX_CYC + 1);
  localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  typedef enum logic [1:0] {RUN = 2'd0, LD_WAIT = 2'd1, MD_WAIT = 2'd2} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_md_cnt, w_md_cnt_nxt;
  logic [FW-1:0] r_flush_cnt;
  logic          r_wb_wr;
  logic [AW-1:0] r_wb_waddr;
  logic          r_md_timeout;
  logic          w_set_timeout;
  logic          w_hit1_mw, w_hit2_mw, w_hit1_wb, w_hit2_wb, w_load_use;
  logic          w_stall, w_stall_mw, w_hold_mw, w_md_start, w_br_acc, w_flush;
  logic [1:0]    w_for_a, w_for_b;

  assign w_hit1_mw = bus.valid_EX & bus.rs1_used & (bus.raddr1 != '0) & bus.reg_wrMW &
                     (bus.raddr1 == bus.waddr_MW);
  assign w_hit2_mw = bus.valid_EX & bus.rs2_used & (bus.raddr2 != '0) & bus.reg_wrMW &
                     (bus.raddr2 == bus.waddr_MW);
  assign w_hit1_wb = bus.valid_EX & bus.rs1_used & (bus.raddr1 != '0) & r_wb_wr &
                     (bus.raddr1 == r_wb_waddr);
  assign w_hit2_wb = bus.valid_EX & bus.rs2_used & (bus.raddr2 != '0) & r_wb_wr &
                     (bus.raddr2 == r_wb_waddr);
  assign w_load_use = bus.is_load_MW & (w_hit1_mw | w_hit2_mw);

  // Load data is not on the MW ALU bus, so a load hit falls through to WB.
  always_comb begin
    w_for_a = 2'b00;
    w_for_b = 2'b00;
    if (w_hit1_mw & ~bus.is_load_MW) w_for_a = 2'b01;
    else if (w_hit1_wb)              w_for_a = 2'b10;
    if (w_hit2_mw & ~bus.is_load_MW) w_for_b = 2'b01;
    else if (w_hit2_wb)              w_for_b = 2'b10;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_md_cnt_nxt  = r_md_cnt;
    w_stall       = 1'b0;
    w_stall_mw    = 1'b0;
    w_hold_mw     = 1'b0;
    w_md_start    = 1'b0;
    w_set_timeout = 1'b0;
    case (r_state)
      RUN: begin
        if (bus.is_load_MW & bus.reg_wrMW & ~bus.load_rdy) begin
          w_stall     = 1'b1;
          w_hold_mw   = 1'b1;
          w_state_nxt = LD_WAIT;
        end else if (w_load_use) begin
          w_stall    = 1'b1;
          w_stall_mw = 1'b1;
        end else if (bus.valid_EX & bus.is_md_EX) begin
          w_md_start   = 1'b1;
          w_stall      = 1'b1;
          w_stall_mw   = 1'b1;
          w_md_cnt_nxt = CW'(1);
          w_state_nxt  = MD_WAIT;
        end
      end
      LD_WAIT: begin
        if (!bus.load_rdy) begin
          w_stall   = 1'b1;
          w_hold_mw = 1'b1;
        end else begin
          w_state_nxt = RUN;
          if (w_load_use) begin
            w_stall    = 1'b1;
            w_stall_mw = 1'b1;
          end
        end
      end
      MD_WAIT: begin
        if (bus.md_done) begin
          w_md_cnt_nxt = '0;
          w_state_nxt  = RUN;
        end else if (r_md_cnt == CW'(MD_MAX_CYC)) begin
          w_set_timeout = 1'b1;
          w_md_cnt_nxt  = '0;
          w_state_nxt   = RUN;
        end else begin
          w_stall      = 1'b1;
          w_stall_mw   = 1'b1;
          w_md_cnt_nxt = r_md_cnt + 1'b1;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  assign w_br_acc = bus.br_taken & ~w_stall;
  assign w_flush  = w_br_acc | (r_flush_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= RUN;
      r_md_cnt     <= '0;
      r_flush_cnt  <= '0;
      r_wb_wr      <= 1'b0;
      r_wb_waddr   <= '0;
      r_md_timeout <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
      if (w_br_acc)                r_flush_cnt <= FW'(FLUSH_CYC - 1);
      else if (r_flush_cnt != '0)  r_flush_cnt <= r_flush_cnt - 1'b1;
      if (w_hold_mw) begin
        r_wb_wr <= 1'b0;
      end else begin
        r_wb_wr    <= bus.reg_wrMW;
        r_wb_waddr <= bus.waddr_MW;
      end
      if (w_set_timeout) r_md_timeout <= 1'b1;
    end
  end

  assign bus.For_A      = rst ? 2'b00 : w_for_a;
  assign bus.For_B      = rst ? 2'b00 : w_for_b;
  assign bus.Stall      = ~rst & w_stall;
  assign bus.Stall_MW   = ~rst & w_stall_mw;
  assign bus.Hold_MW    = ~rst & w_hold_mw;
  assign bus.Flush      = ~rst & w_flush;
  assign bus.md_start   = ~rst & w_md_start;
  assign bus.md_timeout = ~rst & r_md_timeout;
  assign bus.dbg_state  = rst ? 2'b00 : r_state;
endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Bench for hazard_ctrl_mc: directed scenarios plus randomized traffic, checked
// cycle by cycle against a behavioural model through an expected-value queue.
module tb_hazard_ctrl_mc;
  localparam int AW     = 5;
  localparam int MD_MAX = 34;
  localparam int FLUSH  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_mc_if #(.AW(AW)) bus ();

  hazard_ctrl_mc #(.AW(AW), .MD_MAX_CYC(MD_MAX), .FLUSH_CYC(FLUSH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Expected vector: {state, For_A, For_B, Stall, Stall_MW, Hold_MW, Flush, md_start, md_timeout}
  logic [11:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Stimulus fields for the current cycle
  bit s_rst, s_v, s_u1, s_u2, s_md, s_wr, s_ld, s_rdy, s_done, s_br;
  int s_r1, s_r2, s_wa;

  // Reference model state
  bit m_ld_pending;
  int m_md_elapsed;
  int m_flush_left;
  bit m_wb_valid;
  int m_wb_addr;
  bit m_timeout;

  function automatic bit hit(bit used, int ra, bit wr, int wa);
    return s_v && used && (ra != 0) && wr && (ra == wa);
  endfunction

  task automatic idle();
    s_rst = 0; s_v = 0; s_u1 = 0; s_u2 = 0; s_md = 0; s_wr = 0; s_ld = 0;
    s_rdy = 1; s_done = 0; s_br = 0; s_r1 = 0; s_r2 = 0; s_wa = 0;
  endtask

  task automatic step();
    logic [11:0] e;
    int fa, fb, st_code;
    bit h1m, h2m, h1w, h2w, luse, st, smw, hd, ms, acc, fl;
    rst            = s_rst;
    bus.valid_EX   = s_v;
    bus.raddr1     = AW'(s_r1);
    bus.raddr2     = AW'(s_r2);
    bus.rs1_used   = s_u1;
    bus.rs2_used   = s_u2;
    bus.is_md_EX   = s_md;
    bus.reg_wrMW   = s_wr;
    bus.waddr_MW   = AW'(s_wa);
    bus.is_load_MW = s_ld;
    bus.load_rdy   = s_rdy;
    bus.md_done    = s_done;
    bus.br_taken   = s_br;
    if (s_rst) begin
      e = '0;
      m_ld_pending = 0; m_md_elapsed = 0; m_flush_left = 0;
      m_wb_valid = 0; m_wb_addr = 0; m_timeout = 0;
    end else begin
      h1m = hit(s_u1, s_r1, s_wr, s_wa);
      h2m = hit(s_u2, s_r2, s_wr, s_wa);
      h1w = hit(s_u1, s_r1, m_wb_valid, m_wb_addr);
      h2w = hit(s_u2, s_r2, m_wb_valid, m_wb_addr);
      fa = (h1m && !s_ld) ? 1 : (h1w ? 2 : 0);
      fb = (h2m && !s_ld) ? 1 : (h2w ? 2 : 0);
      luse = s_ld && (h1m || h2m);
      st_code = (m_md_elapsed > 0) ? 2 : (m_ld_pending ? 1 : 0);
      st = 0; smw = 0; hd = 0; ms = 0;
      e = {st_code[1:0], fa[1:0], fb[1:0], 6'b0};
      e[0] = m_timeout;
      if (m_md_elapsed > 0) begin
        if (s_done) m_md_elapsed = 0;
        else if (m_md_elapsed == MD_MAX) begin
          m_md_elapsed = 0;
          m_timeout = 1;
        end else begin
          st = 1; smw = 1;
          m_md_elapsed++;
        end
      end else if (m_ld_pending) begin
        if (!s_rdy) begin
          st = 1; hd = 1;
        end else begin
          m_ld_pending = 0;
          if (luse) begin st = 1; smw = 1; end
        end
      end else if (s_ld && s_wr && !s_rdy) begin
        st = 1; hd = 1; m_ld_pending = 1;
      end else if (luse) begin
        st = 1; smw = 1;
      end else if (s_v && s_md) begin
        st = 1; smw = 1; ms = 1; m_md_elapsed = 1;
      end
      acc = s_br && !st;
      fl  = acc || (m_flush_left > 0);
      if (acc) m_flush_left = FLUSH - 1;
      else if (m_flush_left > 0) m_flush_left--;
      if (hd) m_wb_valid = 0;
      else begin
        m_wb_valid = s_wr;
        m_wb_addr  = s_wa;
      end
      e[5:1] = {st, smw, hd, fl, ms};
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic repeat_step(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  always @(negedge clk) begin
    logic [11:0] got, e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = {bus.dbg_state, bus.For_A, bus.For_B, bus.Stall, bus.Stall_MW, bus.Hold_MW,
             bus.Flush, bus.md_start, bus.md_timeout};
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL outputs cyc=%0d got={st,fa,fb,S,SMW,H,F,ms,to}=%b required=%b", cyc, got, e);
      end
    end
  end

  initial begin
    idle();
    s_rst = 1;
    @(posedge clk);
    #1;
    repeat_step(3);
    idle();
    step();

    // MW forwarding, then x0 never forwards
    s_v = 1; s_u1 = 1; s_u2 = 1; s_r1 = 5; s_r2 = 0; s_wr = 1; s_wa = 5;
    step();
    s_r1 = 0; s_wa = 0;
    step();

    // Load-use with data ready, then WB forward
    idle(); s_v = 1; s_u2 = 1; s_r2 = 7; s_ld = 1; s_wr = 1; s_wa = 7;
    step();
    s_ld = 0; s_wr = 0; s_wa = 0;
    step();

    // Variable-latency load, EX unrelated
    idle(); s_v = 1; s_u1 = 1; s_r1 = 3; s_ld = 1; s_wr = 1; s_wa = 7; s_rdy = 0;
    repeat_step(3);
    s_rdy = 1;
    step();
    idle();
    step();

    // mul/div completing after 5 cycles
    s_v = 1; s_md = 1;
    repeat_step(5);
    s_done = 1;
    step();
    idle();
    repeat_step(2);

    // mul/div that never completes -> timeout, sticky
    s_v = 1; s_md = 1;
    repeat_step(MD_MAX + 1);
    idle();
    repeat_step(3);

    // Branch flush, then branch blocked by mul/div stall
    s_br = 1;
    step();
    idle();
    repeat_step(3);
    s_v = 1; s_md = 1; s_br = 1;
    repeat_step(3);
    s_done = 1;
    step();
    idle();
    repeat_step(3);

    // Reset in the middle of a mul/div wait
    s_wr = 1; s_wa = 4;
    step();
    idle(); s_v = 1; s_md = 1;
    repeat_step(4);
    s_rst = 1;
    repeat_step(2);
    idle(); s_v = 1; s_u1 = 1; s_u2 = 1; s_r1 = 4; s_r2 = 4;
    repeat_step(2);

    // Randomized traffic with small register space to make hazards frequent
    for (int i = 0; i < 3000; i++) begin
      s_rst  = ($urandom_range(0, 199) == 0);
      s_v    = ($urandom_range(0, 9) != 0);
      s_r1   = $urandom_range(0, 3);
      s_r2   = $urandom_range(0, 3);
      s_u1   = $urandom_range(0, 1);
      s_u2   = $urandom_range(0, 1);
      s_md   = ($urandom_range(0, 15) == 0);
      s_wr   = ($urandom_range(0, 3) != 0);
      s_wa   = $urandom_range(0, 3);
      s_ld   = ($urandom_range(0, 3) == 0);
      s_rdy  = ($urandom_range(0, 3) != 0);
      s_done = ($urandom_range(0, 7) == 0);
      s_br   = ($urandom_range(0, 7) == 0);
      step();
    end
    idle();
    repeat_step(2);

    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain got=%0d entries required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
